// File: rtl/fp_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_pkg
//  Description : Shared constants and source-select type for the FP
//                register-file write-back controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_wb_pkg;

    // Register 0 is hard-wired to the constant 1.0 and is never written
    localparam logic [31:0] FP_ONE      = 32'h3f80_0000;
    localparam int          FP_ZERO_REG = 0;

    // Write-back source; the value doubles as the request/grant bit index
    typedef enum logic {
        SRC_LD  = 1'b0,
        SRC_FPU = 1'b1
    } src_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-request round-robin arbiter with one-hot grants. The
//                pointer only advances when both requesters contend.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import fp_wb_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [1:0] Req,
    output logic [1:0] Grant
);

    src_e r_ptr;
    logic w_both;

    assign w_both = Req[SRC_LD] & Req[SRC_FPU];

    // Grant the sole requester, or the favoured one when both request
    always_comb begin
        Grant = 2'b00;
        if (w_both) begin
            Grant[r_ptr] = 1'b1;
        end else begin
            Grant = Req;
        end
    end

    // Pointer flips away from the winner after a contended grant only
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr <= SRC_LD;
        end else if (w_both) begin
            r_ptr <= (r_ptr == SRC_LD) ? SRC_FPU : SRC_LD;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_ctrl
//  Description : FP register-file write-back controller. Arbitrates the FPU
//                and load result streams onto the single regfile write port
//                through a registered write stage, and keeps a per-register
//                pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_wb_ctrl
    import fp_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              IssueValid,
    input  logic [REG_AW-1:0] IssueReg,
    output logic              IssueBusy,
    input  logic              FpuValid,
    output logic              FpuReady,
    input  logic [REG_AW-1:0] FpuReg,
    input  logic [DATA_W-1:0] FpuData,
    input  logic              LdValid,
    output logic              LdReady,
    input  logic [REG_AW-1:0] LdReg,
    input  logic [DATA_W-1:0] LdData,
    output logic [DATA_W-1:0] WriteData,
    output logic [REG_AW-1:0] WriteRegister,
    output logic              RegWrite,
    output logic [31:0]       Busy
);

    localparam logic [REG_AW-1:0] C_ZERO_REG = REG_AW'(FP_ZERO_REG);

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_xfer;
    logic [REG_AW-1:0] w_selReg;
    logic [DATA_W-1:0] w_selData;
    logic [31:0]       w_setVec;
    logic [31:0]       w_clrVec;
    logic [31:0]       w_busyNext;

    logic              r_wrEn;
    logic [REG_AW-1:0] r_wrReg;
    logic [DATA_W-1:0] r_wrData;
    logic [31:0]       r_busy;

    assign w_req[SRC_LD]  = LdValid;
    assign w_req[SRC_FPU] = FpuValid;

    rr_arb2 u_arb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Req     (w_req),
        .Grant   (w_grant)
    );

    // Ready is the grant, held low while reset is asserted
    assign LdReady  = w_grant[SRC_LD]  & Reset_n;
    assign FpuReady = w_grant[SRC_FPU] & Reset_n;
    assign w_xfer   = LdReady | FpuReady;

    assign w_selReg  = w_grant[SRC_FPU] ? FpuReg  : LdReg;
    assign w_selData = w_grant[SRC_FPU] ? FpuData : LdData;

    // Write stage: a transfer drives the regfile port for exactly one cycle;
    // transfers to register 0 are accepted but never enable the write
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wrEn   <= 1'b0;
            r_wrReg  <= '0;
            r_wrData <= '0;
        end else begin
            r_wrEn <= w_xfer && (w_selReg != C_ZERO_REG);
            if (w_xfer) begin
                r_wrReg  <= w_selReg;
                r_wrData <= w_selData;
            end
        end
    end

    assign RegWrite      = r_wrEn;
    assign WriteRegister = r_wrReg;
    assign WriteData     = r_wrData;

    // Scoreboard: clear on the regfile capture edge, set on issue; set wins
    // and bit 0 can never become busy
    assign w_setVec   = (IssueValid && (IssueReg != C_ZERO_REG)) ? (32'd1 << IssueReg) : 32'd0;
    assign w_clrVec   = r_wrEn ? (32'd1 << r_wrReg) : 32'd0;
    assign w_busyNext = ((r_busy & ~w_clrVec) | w_setVec) & ~32'd1;

    // Scoreboard register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign Busy      = r_busy;
    assign IssueBusy = |(r_busy & (32'd1 << IssueReg));

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_wb_ctrl
//  Description : Directed self-checking bench for fp_wb_ctrl. Expected writes
//                are queued when a grant is expected and popped when the
//                write stage presents them; a bench-side Busy model tracks
//                the scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_wb_ctrl;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              IssueValid;
    logic [REG_AW-1:0] IssueReg;
    logic              IssueBusy;
    logic              FpuValid;
    logic              FpuReady;
    logic [REG_AW-1:0] FpuReg;
    logic [DATA_W-1:0] FpuData;
    logic              LdValid;
    logic              LdReady;
    logic [REG_AW-1:0] LdReg;
    logic [DATA_W-1:0] LdData;
    logic [DATA_W-1:0] WriteData;
    logic [REG_AW-1:0] WriteRegister;
    logic              RegWrite;
    logic [31:0]       Busy;

    fp_wb_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .IssueValid    (IssueValid),
        .IssueReg      (IssueReg),
        .IssueBusy     (IssueBusy),
        .FpuValid      (FpuValid),
        .FpuReady      (FpuReady),
        .FpuReg        (FpuReg),
        .FpuData       (FpuData),
        .LdValid       (LdValid),
        .LdReady       (LdReady),
        .LdReg         (LdReg),
        .LdData        (LdData),
        .WriteData     (WriteData),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite),
        .Busy          (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic              en;
        logic [REG_AW-1:0] rg;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t         sbq[$];
    wr_t         cur;
    logic [31:0] expBusy;
    int          nPass = 0;
    int          nFail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ldV, input logic [REG_AW-1:0] ldR, input logic [DATA_W-1:0] ldD,
                         input logic fpV, input logic [REG_AW-1:0] fpR, input logic [DATA_W-1:0] fpD,
                         input logic isV, input logic [REG_AW-1:0] isR);
        LdValid = ldV;  LdReg = ldR;  LdData = ldD;
        FpuValid = fpV; FpuReg = fpR; FpuData = fpD;
        IssueValid = isV; IssueReg = isR;
    endtask

    // One clock: check handshake before the edge, check write stage after it
    task automatic tick(input string tag, input logic expLd, input logic expFpu);
        wr_t         e;
        logic [31:0] setv;
        logic [31:0] clrv;
        #1;
        chk({tag, ".LdReady"},   {31'd0, LdReady},   {31'd0, expLd});
        chk({tag, ".FpuReady"},  {31'd0, FpuReady},  {31'd0, expFpu});
        chk({tag, ".IssueBusy"}, {31'd0, IssueBusy}, {31'd0, expBusy[IssueReg]});
        e.en = 1'b0; e.rg = '0; e.d = '0;
        if (expLd) begin
            e.en = (LdReg != 0); e.rg = LdReg; e.d = LdData;
        end else if (expFpu) begin
            e.en = (FpuReg != 0); e.rg = FpuReg; e.d = FpuData;
        end
        if (expLd || expFpu) sbq.push_back(e);
        setv = (IssueValid && IssueReg != 0) ? (32'd1 << IssueReg) : 32'd0;
        clrv = cur.en ? (32'd1 << cur.rg) : 32'd0;
        expBusy = (expBusy & ~clrv) | setv;
        @(posedge Clk);
        #1;
        if (expLd || expFpu) begin
            e = sbq.pop_front();
            cur = e;
            chk({tag, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, e.en});
            if (e.en) begin
                chk({tag, ".WriteRegister"}, {27'd0, WriteRegister}, {27'd0, e.rg});
                chk({tag, ".WriteData"}, WriteData, e.d);
            end
        end else begin
            cur.en = 1'b0;
            chk({tag, ".RegWrite"}, {31'd0, RegWrite}, 32'd0);
        end
        chk({tag, ".Busy"}, Busy, expBusy);
    endtask

    initial begin
        cur.en = 1'b0; cur.rg = '0; cur.d = '0;
        expBusy = 32'd0;

        // Reset with both sources requesting: nothing may be granted
        Reset_n = 1'b0;
        drive(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b1, 5'd4);
        #3;
        chk("rst.RegWrite",      {31'd0, RegWrite}, 32'd0);
        chk("rst.WriteRegister", {27'd0, WriteRegister}, 32'd0);
        chk("rst.WriteData",     WriteData, 32'd0);
        chk("rst.Busy",          Busy, 32'd0);
        chk("rst.LdReady",       {31'd0, LdReady}, 32'd0);
        chk("rst.FpuReady",      {31'd0, FpuReady}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Contention straight after reset: Ld, Fpu, Ld, Fpu
        drive(1'b1, 5'd6, 32'hbeef_0006, 1'b1, 5'd5, 32'hcafe_0005, 1'b0, 5'd0);
        tick("cont0", 1'b1, 1'b0);
        tick("cont1", 1'b0, 1'b1);
        tick("cont2", 1'b1, 1'b0);
        tick("cont3", 1'b0, 1'b1);

        // Load-only transfer
        drive(1'b1, 5'd3, 32'h4049_0fdb, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick("ld", 1'b1, 1'b0);

        // Idle cycle: no write, port holds its last values
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick("idle", 1'b0, 1'b0);
        chk("idle.holdReg",  {27'd0, WriteRegister}, 32'd3);
        chk("idle.holdData", WriteData, 32'h4049_0fdb);

        // Register 0: handshake completes, write suppressed
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0);
        tick("zero", 1'b0, 1'b1);

        // Uncontested grants left the pointer on Ld
        drive(1'b1, 5'd8, 32'h0000_0008, 1'b1, 5'd9, 32'h0000_0009, 1'b0, 5'd0);
        tick("ptr0", 1'b1, 1'b0);
        tick("ptr1", 1'b0, 1'b1);

        // Scoreboard: issue r7, observe busy, write r7 and see it clear
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        tick("iss7", 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
        tick("wait7a", 1'b0, 1'b0);
        tick("wait7b", 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h3f00_0007, 1'b0, 5'd7);
        tick("fpu7", 1'b0, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
        tick("clr7", 1'b0, 1'b0);
        chk("clr7.bit", {31'd0, Busy[7]}, 32'd0);

        // Issue to r0 is ignored
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        tick("iss0", 1'b0, 1'b0);

        // Set and clear of r7 at the same edge: set wins
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        tick("reiss7", 1'b0, 1'b0);
        drive(1'b1, 5'd7, 32'h4000_0007, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        tick("ld7", 1'b1, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        tick("coinc7", 1'b0, 1'b0);
        chk("coinc7.bit", {31'd0, Busy[7]}, 32'd1);

        // Write to a non-busy register still happens
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h5555_aaaa, 1'b1, 5'd10);
        tick("free12", 1'b0, 1'b1);

        // Reset in the cycle after a transfer
        drive(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick("preRst", 1'b1, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("midRst.RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("midRst.Busy",     Busy, 32'd0);
        chk("midRst.WriteReg", {27'd0, WriteRegister}, 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        sbq.delete();
        cur.en = 1'b0;
        expBusy = 32'd0;
        @(negedge Clk);
        Reset_n = 1'b1;
        tick("postRst0", 1'b0, 1'b0);
        tick("postRst1", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nPass + nFail);
        $finish;
    end

endmodule
`default_nettype wire
